// File: rtl/matrix_mult_seq.sv
// Sequential N x N unsigned matrix multiplier: latches operands on start, produces one result row per N cycles.
// Define MATMUL_SAT_EN to saturate result elements and add the sat_flag output.
module matrix_mult_seq #(
   parameter int unsigned N  = 10,
   parameter int unsigned DW = 8,
   parameter int unsigned OW = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [N*N*DW-1:0]   matrix_a,
   input  logic [N*N*DW-1:0]   matrix_b,
   output logic                busy,
   output logic                done,
`ifdef MATMUL_SAT_EN
   output logic                sat_flag,
`endif
   output logic [N*N*OW-1:0]   result
);

   localparam int unsigned CW = $clog2(N);
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned AW = 2 * DW + $clog2(N);

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   state_t              state;
   logic [N*N*DW-1:0]   a_reg;
   logic [N*N*DW-1:0]   b_reg;
   logic [CW-1:0]       row_i;
   logic [CW-1:0]       k_cnt;
   logic [AW-1:0]       acc    [N];

   logic [DW-1:0]       a_elem_c;
   logic [DW-1:0]       b_elem_c [N];
   logic [PW-1:0]       prod_c   [N];
   logic [AW-1:0]       sum_c    [N];
   logic [OW-1:0]       conv_c   [N];
`ifdef MATMUL_SAT_EN
   logic [N-1:0]        sat_c;
`endif

   // One MAC lane per column: A[i][k] is shared, B[k][j] differs per lane
   always_comb begin
      a_elem_c = a_reg[DW*(N*int'(row_i) + int'(k_cnt)) +: DW];
      for (int j = 0; j < N; j++) begin
         b_elem_c[j] = b_reg[DW*(N*int'(k_cnt) + j) +: DW];
         prod_c[j]   = PW'(a_elem_c) * PW'(b_elem_c[j]);
         sum_c[j]    = acc[j] + AW'(prod_c[j]);
`ifdef MATMUL_SAT_EN
         sat_c[j]    = |(sum_c[j] >> OW);
         conv_c[j]   = sat_c[j] ? {OW{1'b1}} : sum_c[j][OW-1:0];
`else
         conv_c[j]   = sum_c[j][OW-1:0];
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         row_i  <= '0;
         k_cnt  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
`ifdef MATMUL_SAT_EN
         sat_flag <= 1'b0;
`endif
         for (int j = 0; j < N; j++) acc[j] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= matrix_a;
                  b_reg <= matrix_b;
                  row_i <= '0;
                  k_cnt <= '0;
                  busy  <= 1'b1;
`ifdef MATMUL_SAT_EN
                  sat_flag <= 1'b0;
`endif
                  for (int j = 0; j < N; j++) acc[j] <= '0;
                  state <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (k_cnt == CW'(N - 1)) begin
                  // Last k of the row: commit final sums and restart the lanes
                  for (int j = 0; j < N; j++) begin
                     result[OW*(N*int'(row_i) + j) +: OW] <= conv_c[j];
                     acc[j] <= '0;
                  end
`ifdef MATMUL_SAT_EN
                  sat_flag <= sat_flag | (|sat_c);
`endif
                  k_cnt <= '0;
                  if (row_i == CW'(N - 1)) begin
                     state <= DONE;
                  end else begin
                     row_i <= row_i + CW'(1);
                  end
               end else begin
                  for (int j = 0; j < N; j++) acc[j] <= sum_c[j];
                  k_cnt <= k_cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Scoreboard bench for matrix_mult_seq (N=10, DW=8, OW=8); builds with or without MATMUL_SAT_EN.
`timescale 1ns/1ps
module tb_matrix_mult_seq;

   localparam int N  = 10;
   localparam int DW = 8;
   localparam int OW = 8;
   localparam int AB = N*N*DW;
   localparam int RB = N*N*OW;

   localparam int K_IDENT = 0;
   localparam int K_RAMP  = 1;
   localparam int K_ONES  = 2;
   localparam int K_MAX   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AB-1:0] matrix_a;
   logic [AB-1:0] matrix_b;
   logic          busy;
   logic          done;
   logic [RB-1:0] result;
`ifdef MATMUL_SAT_EN
   logic          sat_flag;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [RB-1:0] exp_q [$];
   bit            sat_q [$];

   matrix_mult_seq #(.N(N), .DW(DW), .OW(OW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .matrix_a (matrix_a),
      .matrix_b (matrix_b),
      .busy     (busy),
      .done     (done),
`ifdef MATMUL_SAT_EN
      .sat_flag (sat_flag),
`endif
      .result   (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int elem(input int kind, input int r, input int c);
      case (kind)
         K_IDENT: return (r == c) ? 1 : 0;
         K_RAMP:  return (r*10 + c) % 256;
         K_ONES:  return 1;
         default: return 255;
      endcase
   endfunction

   function automatic logic [AB-1:0] mk_op(input int kind);
      logic [AB-1:0] v;
      v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            v[DW*(N*r+c) +: DW] = DW'(elem(kind, r, c));
      return v;
   endfunction

   function automatic logic [RB-1:0] mk_res(input int kind, input int cval);
      logic [RB-1:0] v;
      v = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            v[OW*(N*r+c) +: OW] = (kind == K_RAMP) ? OW'(elem(K_RAMP, r, c)) : OW'(cval);
      return v;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Called #1 after a posedge with the DUT idle; returns with t0 = start edge
   task automatic start_op(input logic [AB-1:0] a, input logic [AB-1:0] b,
                           input logic [RB-1:0] ex, input bit es, input bit push,
                           output int t0);
      matrix_a = a;
      matrix_b = b;
      start    = 1'b1;
      if (push) begin
         exp_q.push_back(ex);
         sat_q.push_back(es);
      end
      @(posedge clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   // Counts busy samples from now, then waits (bounded) for done; lat is relative to t0
   task automatic wait_done(input int t0, output int lat, output int bcnt);
      lat  = -1;
      bcnt = 0;
      for (int e = 0; e <= 400; e++) begin
         if (e > 0) begin
            @(posedge clk); #1;
            if (done) begin
               lat = cyc - t0;
               break;
            end
         end
         if (busy) bcnt++;
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected result
   always @(negedge clk) begin : monitor
      logic [RB-1:0] ex;
      bit            es;
      int            nbad;
      int            first;
      if (!reset && done) begin
         done_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: done at cycle %0d with no expected result", cyc);
         end else begin
            ex    = exp_q.pop_front();
            es    = sat_q.pop_front();
            nbad  = 0;
            first = -1;
            for (int i = 0; i < N*N; i++) begin
               if (result[OW*i +: OW] !== ex[OW*i +: OW]) begin
                  nbad++;
                  if (first < 0) first = i;
               end
            end
            if (nbad != 0) begin
               bad++;
               $display("FAIL result: %0d elements wrong, element %0d got %0d expected %0d",
                        nbad, first, result[OW*first +: OW], ex[OW*first +: OW]);
            end
`ifdef MATMUL_SAT_EN
            total++;
            if (sat_flag !== es) begin
               bad++;
               $display("FAIL sat_flag: got %0b expected %0b", sat_flag, es);
            end
`endif
         end
      end
   end

   initial begin
      int t0, lat, bcnt, dc0;
      logic [RB-1:0] r_ident, r_ones, r_max;
      bit sat_max;

      r_ident = mk_res(K_RAMP, 0);
      r_ones  = mk_res(K_ONES, 10);
`ifdef MATMUL_SAT_EN
      r_max   = mk_res(K_MAX, 8'hFF);
      sat_max = 1'b1;
`else
      r_max   = mk_res(K_MAX, 8'h0A);
      sat_max = 1'b0;
`endif

      reset = 1'b1;
      start = 1'b0;
      matrix_a = '0;
      matrix_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_result_ones", $countones(result), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Identity x ramp with full timing checks
      start_op(mk_op(K_IDENT), mk_op(K_RAMP), r_ident, 1'b0, 1'b1, t0);
      check("ident_busy_after_start", int'(busy), 1);
      wait_done(t0, lat, bcnt);
      check("ident_done_latency", lat, 101);
      check("ident_busy_cycles", bcnt, 101);
      check("ident_done_busy_low", int'(busy), 0);
      @(posedge clk); #1;
      check("ident_done_single", int'(done), 0);

      // All ones
      start_op(mk_op(K_ONES), mk_op(K_ONES), r_ones, 1'b0, 1'b1, t0);
      wait_done(t0, lat, bcnt);
      check("ones_done_latency", lat, 101);
      @(posedge clk); #1;

      // All 255: overflow path
      start_op(mk_op(K_MAX), mk_op(K_MAX), r_max, sat_max, 1'b1, t0);
      wait_done(t0, lat, bcnt);
      check("max_done_latency", lat, 101);
      @(posedge clk); #1;

      // Start pulses during compute must be ignored
      dc0 = done_cnt;
      start_op(mk_op(K_IDENT), mk_op(K_RAMP), r_ident, 1'b0, 1'b1, t0);
      for (int e = 1; e <= 50; e++) begin
         start = (e == 5 || e == 50);
         matrix_a = (e == 5) ? mk_op(K_ONES) : mk_op(K_MAX);
         matrix_b = (e == 5) ? mk_op(K_ONES) : mk_op(K_MAX);
         @(posedge clk); #1;
      end
      start = 1'b0;
      wait_done(t0, lat, bcnt);
      check("ignore_done_latency", lat, 101);
      repeat (5) @(posedge clk);
      #1;
      check("ignore_done_count", done_cnt - dc0, 1);

      // Reset in the middle of compute
      start_op(mk_op(K_ONES), mk_op(K_ONES), '0, 1'b0, 1'b0, t0);
      repeat (50) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_busy", int'(busy), 0);
      check("midreset_done", int'(done), 0);
      check("midreset_result_ones", $countones(result), 0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk); #1;
      start_op(mk_op(K_IDENT), mk_op(K_RAMP), r_ident, 1'b0, 1'b1, t0);
      wait_done(t0, lat, bcnt);
      check("after_reset_done_latency", lat, 101);
      check("after_reset_busy_cycles", bcnt, 101);
      @(posedge clk); #1;

      // Back-to-back with start held high; operands change after the first accept
      matrix_a = mk_op(K_IDENT);
      matrix_b = mk_op(K_RAMP);
      start = 1'b1;
      exp_q.push_back(r_ident);
      sat_q.push_back(1'b0);
      exp_q.push_back(r_ones);
      sat_q.push_back(1'b0);
      @(posedge clk); #1;
      t0 = cyc;
      matrix_a = mk_op(K_ONES);
      matrix_b = mk_op(K_ONES);
      wait_done(t0, lat, bcnt);
      check("b2b_first_done", lat, 101);
      check("b2b_first_busy_cycles", bcnt, 101);
      wait_done(t0, lat, bcnt);
      start = 1'b0;
      check("b2b_second_done", lat, 203);
      check("b2b_second_busy_cycles", bcnt, 101);
      repeat (4) @(posedge clk);
      #1;
      check("b2b_no_third_op", int'(busy), 0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
